// File: rtl/cuckoo_pkg.sv
// Constants shared by the cuckoo-hash feeder, the insertion engine and the table storage.
package cuckoo_pkg;

   localparam int KEY_W    = 32;
   localparam int IDX_W    = 5;
   localparam int TBL_SIZE = 2 ** IDX_W;

   localparam logic [KEY_W-1:0] H1_MULT = 32'h9E3779B1;
   localparam logic [KEY_W-1:0] H2_MULT = 32'h85EBCA77;

endpackage

// File: rtl/hash_key_fifo.sv
// Circular FIFO with occupancy count; push when full and pop when empty are ignored.
module hash_key_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/cuckoo_hash_gen.sv
// Key feeder for the cuckoo insertion engine: buffers keys, hashes them into two
// distinct table slots, and hands key plus slot pair downstream over valid/ready.
module cuckoo_hash_gen #(
   parameter int                         IDX_W      = cuckoo_pkg::IDX_W,
   parameter int                         FIFO_DEPTH = 4,
   parameter logic [cuckoo_pkg::KEY_W-1:0] H1_MULT  = cuckoo_pkg::H1_MULT,
   parameter logic [cuckoo_pkg::KEY_W-1:0] H2_MULT  = cuckoo_pkg::H2_MULT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [cuckoo_pkg::KEY_W-1:0]  in_key,
   output logic                          in_ready,
   output logic                          out_valid,
   output logic [cuckoo_pkg::KEY_W-1:0]  out_num,
   output logic [IDX_W-1:0]              out_index1,
   output logic [IDX_W-1:0]              out_index2,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [15:0]                   keys_issued,
   output logic                          busy
);

   import cuckoo_pkg::KEY_W;

   logic             ready_en;
   logic             fifo_full;
   logic             fifo_empty;
   logic [KEY_W-1:0] fifo_head;
   logic [KEY_W-1:0] prod1;
   logic [KEY_W-1:0] prod2;

   logic             s1_valid;
   logic [KEY_W-1:0] s1_key;
   logic [IDX_W-1:0] s1_h1;
   logic [IDX_W-1:0] s1_h2;

   logic             s2_fire;
   logic             s1_adv;
   logic             s1_load;
   logic [IDX_W-1:0] idx2;

   // Holds in_ready low through reset and for the first edge after release.
   always_ff @(posedge clk) begin
      if (!reset) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   assign in_ready = ready_en && !fifo_full;
   assign s2_fire  = out_valid && out_ready;
   assign s1_adv   = s1_valid && (!out_valid || out_ready);
   assign s1_load  = !fifo_empty && (!s1_valid || s1_adv);

   hash_key_fifo #(
      .WIDTH (KEY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid && in_ready),
      .wdata (in_key),
      .pop   (s1_load),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign prod1 = fifo_head * H1_MULT;
   assign prod2 = fifo_head * H2_MULT;

   // Only the top IDX_W bits of each product ever select a slot, so only those are kept.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_key   <= '0;
         s1_h1    <= '0;
         s1_h2    <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_key   <= fifo_head;
         s1_h1    <= prod1[KEY_W-1 -: IDX_W];
         s1_h2    <= prod2[KEY_W-1 -: IDX_W];
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // A key must land in two different slots, so a collision flips the LSB of slot 1.
   assign idx2 = (s1_h2 != s1_h1) ? s1_h2 : (s1_h1 ^ IDX_W'(1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_num    <= '0;
         out_index1 <= '0;
         out_index2 <= '0;
      end else if (s1_adv) begin
         out_valid  <= 1'b1;
         out_num    <= s1_key;
         out_index1 <= s1_h1;
         out_index2 <= idx2;
      end else if (s2_fire) begin
         out_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)       keys_issued <= '0;
      else if (s2_fire) keys_issued <= keys_issued + 16'd1;
   end

   assign busy = (fifo_count != '0) || s1_valid || out_valid;

endmodule

// File: tb/tb_cuckoo_hash_gen.sv
// Directed self-checking bench for cuckoo_hash_gen: reset, hashing, back-pressure,
// ordering under a toggling ready, mid-stream reset and issue-counter wrap.
module tb_cuckoo_hash_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_key = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_num;
   logic [4:0]  out_index1;
   logic [4:0]  out_index2;
   logic        out_ready = 1'b0;
   logic [2:0]  fifo_count;
   logic [15:0] keys_issued;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cuckoo_hash_gen dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_key      (in_key),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_num     (out_num),
      .out_index1  (out_index1),
      .out_index2  (out_index2),
      .out_ready   (out_ready),
      .fifo_count  (fifo_count),
      .keys_issued (keys_issued),
      .busy        (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference slot pair: top 5 bits of each 32-bit product, collision resolved by flipping the LSB.
   function automatic void hash_model(input logic [31:0] k, output logic [4:0] i1, output logic [4:0] i2);
      logic [31:0] p1;
      logic [31:0] p2;
      logic [4:0]  r2;
      p1 = k * 32'h9E3779B1;
      p2 = k * 32'h85EBCA77;
      i1 = p1[31:27];
      r2 = p2[31:27];
      i2 = (r2 != i1) ? r2 : {i1[4:1], ~i1[0]};
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %0h want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %0h want 0", in_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0h want 0", busy); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_fifo_count: got %0d want 0", fifo_count); end
      n_checks++; if (keys_issued !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_keys_issued: got %0d want 0", keys_issued); end
      n_checks++; if ({out_num, out_index1, out_index2} !== 42'd0) begin n_fail++; $display("[TB] FAIL reset_data: got %h/%0d/%0d want 0/0/0", out_num, out_index1, out_index2); end
      reset = 1'b1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL release_in_ready_early: got %0h want 0", in_ready); end
      step();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready: got %0h want 1", in_ready); end
   endtask

   task automatic test_single_zero();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_key = 32'h0000_0000;
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_lat_n0: got %0h want 0", out_valid); end
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_lat_n1: got %0h want 0", out_valid); end
      step();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_lat_n2: got %0h want 1", out_valid); end
      n_checks++; if (out_num !== 32'h0) begin n_fail++; $display("[TB] FAIL zero_num: got %h want 0", out_num); end
      n_checks++; if (out_index1 !== 5'd0) begin n_fail++; $display("[TB] FAIL zero_index1: got %0d want 0", out_index1); end
      n_checks++; if (out_index2 !== 5'd1) begin n_fail++; $display("[TB] FAIL zero_index2: got %0d want 1", out_index2); end
      step();
      n_checks++; if (keys_issued !== 16'd1) begin n_fail++; $display("[TB] FAIL zero_keys_issued: got %0d want 1", keys_issued); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_drained: got %0h want 0", out_valid); end
   endtask

   task automatic test_key_one();
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_key = 32'h0000_0001;
      step();
      in_valid = 1'b0;
      step();
      step();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL one_valid: got %0h want 1", out_valid); end
      n_checks++; if (out_num !== 32'h1) begin n_fail++; $display("[TB] FAIL one_num: got %h want 1", out_num); end
      n_checks++; if (out_index1 !== 5'd19) begin n_fail++; $display("[TB] FAIL one_index1: got %0d want 19", out_index1); end
      n_checks++; if (out_index2 !== 5'd16) begin n_fail++; $display("[TB] FAIL one_index2: got %0d want 16", out_index2); end
      step();
      n_checks++; if (keys_issued !== 16'd1) begin n_fail++; $display("[TB] FAIL one_keys_issued: got %0d want 1", keys_issued); end
   endtask

   task automatic test_burst();
      logic [31:0] keys [7];
      logic [4:0]  e1;
      logic [4:0]  e2;
      int          got;
      keys = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
               32'h5555_0005, 32'h6666_0006, 32'h7777_0007};
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_key = keys[i];
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_accept_%0d: in_ready %0h want 1", i, in_ready); end
         step();
      end
      in_key = keys[6];
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL burst_full_ready: got %0h want 0", in_ready); end
      n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("[TB] FAIL burst_fifo_count: got %0d want 4", fifo_count); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_busy: got %0h want 1", busy); end
      step();
      in_valid = 1'b0;
      step();
      n_checks++; if (out_num !== keys[0] || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_stall_hold: got %h/%0h want %h/1", out_num, out_valid, keys[0]); end
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 6; c++) begin
         if (out_valid === 1'b1) begin
            hash_model(keys[got], e1, e2);
            n_checks++; if (out_num !== keys[got]) begin n_fail++; $display("[TB] FAIL burst_order_%0d: got %h want %h", got, out_num, keys[got]); end
            n_checks++; if (out_index1 !== e1 || out_index2 !== e2) begin n_fail++; $display("[TB] FAIL burst_idx_%0d: got %0d/%0d want %0d/%0d", got, out_index1, out_index2, e1, e2); end
            got++;
         end
         step();
      end
      n_checks++; if (got != 6) begin n_fail++; $display("[TB] FAIL burst_drain_count: got %0d want 6", got); end
      n_checks++; if (keys_issued !== 16'd6) begin n_fail++; $display("[TB] FAIL burst_keys_issued: got %0d want 6", keys_issued); end
      step();
      step();
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("[TB] FAIL burst_idle: got valid %0h busy %0h count %0d want 0/0/0", out_valid, busy, fifo_count); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q [$];
      logic [31:0] hold_num;
      logic [4:0]  hold_i1;
      logic [4:0]  hold_i2;
      logic [4:0]  e1;
      logic [4:0]  e2;
      logic        held;
      int          pushed;
      int          popped;
      do_reset();
      pushed = 0;
      popped = 0;
      held = 1'b0;
      hold_num = '0;
      hold_i1 = '0;
      hold_i2 = '0;
      for (int c = 0; c < 200 && popped < 12; c++) begin
         if (held) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_num !== hold_num || out_index1 !== hold_i1 || out_index2 !== hold_i2) begin
               n_fail++;
               $display("[TB] FAIL b2b_stable: got %0h %h %0d %0d want 1 %h %0d %0d", out_valid, out_num, out_index1, out_index2, hold_num, hold_i1, hold_i2);
            end
         end
         out_ready = ~out_ready;
         held = 1'b0;
         if (out_valid === 1'b1) begin
            if (out_ready) begin
               n_checks++;
               if (q.size() == 0) begin
                  n_fail++;
                  $display("[TB] FAIL b2b_extra: got %h want none", out_num);
               end else begin
                  hash_model(q[0], e1, e2);
                  if (out_num !== q[0] || out_index1 !== e1 || out_index2 !== e2) begin
                     n_fail++;
                     $display("[TB] FAIL b2b_data: got %h %0d %0d want %h %0d %0d", out_num, out_index1, out_index2, q[0], e1, e2);
                  end
                  void'(q.pop_front());
               end
               popped++;
            end else begin
               held = 1'b1;
               hold_num = out_num;
               hold_i1 = out_index1;
               hold_i2 = out_index2;
            end
         end
         if (pushed < 12) begin
            in_valid = 1'b1;
            in_key = 32'hA5A5_0000 + pushed * 32'h0101_0101;
            if (in_ready === 1'b1) begin
               q.push_back(in_key);
               pushed++;
            end
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      in_valid = 1'b0;
      n_checks++; if (popped != 12 || q.size() != 0) begin n_fail++; $display("[TB] FAIL b2b_complete: got %0d out %0d left want 12 out 0 left", popped, q.size()); end
      n_checks++; if (keys_issued !== 16'd12) begin n_fail++; $display("[TB] FAIL b2b_keys_issued: got %0d want 12", keys_issued); end
   endtask

   task automatic test_reset_mid();
      logic [4:0] e1;
      logic [4:0] e2;
      int         w;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_key = 32'hC0DE_0000 + i;
         step();
      end
      in_valid = 1'b0;
      n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("[TB] FAIL mid_buffered: got %0d want 3", fifo_count); end
      reset = 1'b0;
      out_ready = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_out_valid: got %0h want 0", out_valid); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("[TB] FAIL mid_fifo_count: got %0d want 0", fifo_count); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy: got %0h want 0", busy); end
      n_checks++; if (keys_issued !== 16'd0) begin n_fail++; $display("[TB] FAIL mid_no_handshake: got %0d want 0", keys_issued); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_in_ready: got %0h want 0", in_ready); end
      reset = 1'b1;
      step();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_release_ready: got %0h want 1", in_ready); end
      in_valid = 1'b1;
      in_key = 32'hDEAD_BEEF;
      step();
      in_valid = 1'b0;
      w = 0;
      while (out_valid !== 1'b1 && w < 6) begin
         step();
         w++;
      end
      hash_model(32'hDEAD_BEEF, e1, e2);
      n_checks++; if (out_valid !== 1'b1 || w != 2) begin n_fail++; $display("[TB] FAIL mid_new_latency: got valid %0h after %0d want 1 after 2", out_valid, w); end
      n_checks++; if (out_num !== 32'hDEAD_BEEF || out_index1 !== e1 || out_index2 !== e2) begin n_fail++; $display("[TB] FAIL mid_new_data: got %h %0d %0d want deadbeef %0d %0d", out_num, out_index1, out_index2, e1, e2); end
      step();
      n_checks++; if (keys_issued !== 16'd1) begin n_fail++; $display("[TB] FAIL mid_keys_issued: got %0d want 1", keys_issued); end
   endtask

   task automatic test_wrap();
      logic [31:0] q [$];
      logic [4:0]  e1;
      logic [4:0]  e2;
      int          pushed;
      int          n_out;
      do_reset();
      out_ready = 1'b1;
      pushed = 0;
      n_out = 0;
      for (int c = 0; c < 70000 && n_out < 65537; c++) begin
         if (out_valid === 1'b1) begin
            n_checks++;
            if (out_index1 === out_index2) begin n_fail++; $display("[TB] FAIL wrap_idx_distinct: got %0d and %0d want different", out_index1, out_index2); end
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL wrap_extra: got %h want none", out_num);
            end else begin
               hash_model(q[0], e1, e2);
               if (out_num !== q[0] || out_index1 !== e1 || out_index2 !== e2) begin
                  n_fail++;
                  $display("[TB] FAIL wrap_data_%0d: got %h %0d %0d want %h %0d %0d", n_out, out_num, out_index1, out_index2, q[0], e1, e2);
               end
               void'(q.pop_front());
            end
            n_out++;
         end
         if (pushed < 65537) begin
            in_valid = 1'b1;
            in_key = 32'(pushed) * 32'h2545_F491 + 32'h1357_9BDF;
            if (in_ready === 1'b1) begin
               q.push_back(in_key);
               pushed++;
            end
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      in_valid = 1'b0;
      n_checks++; if (n_out != 65537) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d want 65537", n_out); end
      n_checks++; if (keys_issued !== 16'd1) begin n_fail++; $display("[TB] FAIL wrap_keys_issued: got %0d want 1", keys_issued); end
   endtask

   initial begin
      test_reset();
      test_single_zero();
      test_key_one();
      test_burst();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
